// File: rtl/keypad_entry_pkg.sv
// Shared constants, LCD sequencer states and the BCD-to-segment decoder
// for the keypad entry front end.
package keypad_pkg;

  localparam logic [7:0] SEG_0   = 8'hFC;
  localparam logic [7:0] SEG_1   = 8'h60;
  localparam logic [7:0] SEG_2   = 8'hDA;
  localparam logic [7:0] SEG_3   = 8'hF2;
  localparam logic [7:0] SEG_4   = 8'h66;
  localparam logic [7:0] SEG_5   = 8'hB6;
  localparam logic [7:0] SEG_6   = 8'hBE;
  localparam logic [7:0] SEG_7   = 8'hE0;
  localparam logic [7:0] SEG_8   = 8'hFE;
  localparam logic [7:0] SEG_9   = 8'hF6;
  localparam logic [7:0] SEG_BLK = 8'h00;

  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_CUR_LEFT   = 8'h10;
  localparam logic [7:0] LCD_SPACE      = 8'h20;
  localparam logic [7:0] LCD_DIGIT_BASE = 8'h30;

  // Switch bank layout: digit keys run from bit 11 (key 0) down to bit 2 (key 9)
  localparam int NUM_KEYS  = 12;
  localparam int KEY_BKSP  = 0;
  localparam int KEY_CLEAR = 1;
  localparam int KEY_D9    = 2;
  localparam int KEY_D0    = 11;

  typedef enum logic [1:0] {
    LCD_IDLE  = 2'd0,
    LCD_SEND1 = 2'd1,
    LCD_SEND2 = 2'd2,
    LCD_SEND3 = 2'd3
  } lcd_state_e;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLK;
    endcase
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Byte stream from the keypad entry stage to the LCD writer (valid/ready).
interface keypad_entry_if;
  import keypad_pkg::*;

  logic [7:0] o_lcd_data;
  logic       o_lcd_rs;
  logic       o_lcd_valid;
  logic       i_lcd_ready;

  modport master (output o_lcd_data, output o_lcd_rs, output o_lcd_valid, input  i_lcd_ready);
  modport slave  (input  o_lcd_data, input  o_lcd_rs, input  o_lcd_valid, output i_lcd_ready);
endinterface

// File: rtl/keypad_entry_sw_debounce.sv
// Whole-vector switch debouncer; strobes a key event when the accepted state
// moves from all-released to exactly one pressed key.
module sw_debounce
  import keypad_pkg::*;
#(
  parameter int WIDTH      = NUM_KEYS,
  parameter int DEB_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         sw,
  output logic [WIDTH-1:0]         stable,
  output logic                     evt,
  output logic [$clog2(WIDTH)-1:0] evt_idx
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    cnt;

  function automatic logic [IW-1:0] idx_of(input logic [WIDTH-1:0] v);
    idx_of = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx_of = IW'(i);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= '0;
      cnt     <= '0;
      stable  <= '0;
      evt     <= 1'b0;
      evt_idx <= '0;
    end else begin
      evt <= 1'b0;
      if (sw != prev) begin
        prev <= sw;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else if (stable != prev) begin
        // Only a release-to-single-key transition is a key event
        stable  <= prev;
        evt     <= (stable == '0) && $onehot(prev);
        evt_idx <= idx_of(prev);
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry stage: BCD entry buffer with clear/backspace, LCD byte
// sequencer and a scanned multi-digit 7-segment display.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 16,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         i_sw_push,
  output logic [7:0]                  o_seg,
  output logic [DIGITS-1:0]           o_seg_sel,
  output logic [4*DIGITS-1:0]         o_value,
  output logic [$clog2(DIGITS+1)-1:0] o_count,
  output logic                        o_full,
  keypad_entry_if.master              lcd
);

  localparam int CNTW = $clog2(DIGITS + 1);
  localparam int PW   = $clog2(DIGITS);
  localparam int DW   = $clog2(SCAN_DIV + 1);
  localparam int KW   = $clog2(NUM_KEYS);

  localparam logic [1:0] ST_IDLE  = LCD_IDLE;
  localparam logic [1:0] ST_SEND1 = LCD_SEND1;
  localparam logic [1:0] ST_SEND2 = LCD_SEND2;
  localparam logic [1:0] ST_SEND3 = LCD_SEND3;

  logic [NUM_KEYS-1:0] db_stable_unused;
  logic                key_evt;
  logic [KW-1:0]       key_idx;

  sw_debounce #(.WIDTH(NUM_KEYS), .DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .sw      (i_sw_push),
    .stable  (db_stable_unused),
    .evt     (key_evt),
    .evt_idx (key_idx)
  );

  logic [1:0]          state, state_nxt;
  logic                bs_seq, bs_seq_nxt;
  logic [4*DIGITS-1:0] value_nxt;
  logic [CNTW-1:0]     count_nxt;
  logic [7:0]          data_nxt;
  logic                rs_nxt, valid_nxt;
  logic [3:0]          digit;

  always_comb begin
    value_nxt  = o_value;
    count_nxt  = o_count;
    state_nxt  = state;
    bs_seq_nxt = bs_seq;
    data_nxt   = lcd.o_lcd_data;
    rs_nxt     = lcd.o_lcd_rs;
    valid_nxt  = lcd.o_lcd_valid;
    digit      = 4'(KEY_D0 - int'(key_idx));
    case (state)
      // Events are only honoured in IDLE so buffer and LCD never diverge
      ST_IDLE: begin
        if (key_evt) begin
          if (int'(key_idx) >= KEY_D9) begin
            if (o_count != CNTW'(DIGITS)) begin
              value_nxt  = {o_value[4*DIGITS-5:0], digit};
              count_nxt  = o_count + 1'b1;
              data_nxt   = LCD_DIGIT_BASE + {4'd0, digit};
              rs_nxt     = 1'b1;
              valid_nxt  = 1'b1;
              bs_seq_nxt = 1'b0;
              state_nxt  = ST_SEND1;
            end
          end else if (int'(key_idx) == KEY_CLEAR) begin
            value_nxt  = '0;
            count_nxt  = '0;
            data_nxt   = LCD_CLEAR;
            rs_nxt     = 1'b0;
            valid_nxt  = 1'b1;
            bs_seq_nxt = 1'b0;
            state_nxt  = ST_SEND1;
          end else if (o_count != '0) begin
            value_nxt  = {4'd0, o_value[4*DIGITS-1:4]};
            count_nxt  = o_count - 1'b1;
            data_nxt   = LCD_CUR_LEFT;
            rs_nxt     = 1'b0;
            valid_nxt  = 1'b1;
            bs_seq_nxt = 1'b1;
            state_nxt  = ST_SEND1;
          end
        end
      end
      ST_SEND1: begin
        if (lcd.i_lcd_ready) begin
          if (bs_seq) begin
            data_nxt  = LCD_SPACE;
            rs_nxt    = 1'b1;
            state_nxt = ST_SEND2;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_SEND2: begin
        if (lcd.i_lcd_ready) begin
          data_nxt  = LCD_CUR_LEFT;
          rs_nxt    = 1'b0;
          state_nxt = ST_SEND3;
        end
      end
      ST_SEND3: begin
        if (lcd.i_lcd_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  logic [DW-1:0]     scan_div, div_nxt;
  logic [PW-1:0]     scan_pos, pos_nxt;
  logic [7:0]        seg_nxt;
  logic              div_wrap;

  // Segment data is decoded from next-state values so o_seg tracks o_seg_sel
  always_comb begin
    div_wrap = (scan_div == DW'(SCAN_DIV - 1));
    div_nxt  = div_wrap ? '0 : scan_div + 1'b1;
    pos_nxt  = scan_pos;
    if (div_wrap)
      pos_nxt = (scan_pos == PW'(DIGITS - 1)) ? '0 : scan_pos + 1'b1;
    seg_nxt = SEG_BLK;
    if (count_nxt == '0) begin
      if (pos_nxt == '0) seg_nxt = SEG_0;
    end else if (int'(pos_nxt) < int'(count_nxt)) begin
      seg_nxt = bcd_to_seg(value_nxt[4*pos_nxt +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_value         <= '0;
      o_count         <= '0;
      o_full          <= 1'b0;
      state           <= ST_IDLE;
      bs_seq          <= 1'b0;
      lcd.o_lcd_data  <= 8'h00;
      lcd.o_lcd_rs    <= 1'b0;
      lcd.o_lcd_valid <= 1'b0;
      scan_div        <= '0;
      scan_pos        <= '0;
      o_seg_sel       <= DIGITS'(1);
      o_seg           <= SEG_0;
    end else begin
      o_value         <= value_nxt;
      o_count         <= count_nxt;
      o_full          <= (count_nxt == CNTW'(DIGITS));
      state           <= state_nxt;
      bs_seq          <= bs_seq_nxt;
      lcd.o_lcd_data  <= data_nxt;
      lcd.o_lcd_rs    <= rs_nxt;
      lcd.o_lcd_valid <= valid_nxt;
      scan_div        <= div_nxt;
      scan_pos        <= pos_nxt;
      o_seg_sel       <= DIGITS'(1) << pos_nxt;
      o_seg           <= seg_nxt;
    end
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Multi-digit keypad entry stage for the calculator front end. Debounces the 12-key one-hot push-switch bank, accumulates up to DIGITS decimal digits in a BCD entry buffer with clear and backspace editing, and drives a scanned multi-digit 7-segment display. It also streams matching character and command bytes to the LCD writer over a valid/ready handshake. Sits between the switch pins and the arithmetic core, which reads the BCD value.

## Interface
- DIGITS, 4: entry buffer depth and number of 7-segment digits (≥2).
- DEB_CYCLES, 16: consecutive identical samples required to accept a switch state (≥2).
- SCAN_DIV, 1000: clock cycles each display digit stays selected (≥1).

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_sw_push  input  12  raw push switches; bit 11 = key 0 … bit 2 = key 9, bit 1 = CLEAR, bit 0 = BACKSPACE.
- o_seg  output  8  segment pattern for the selected digit (a..g,dp, MSB = a).
- o_seg_sel  output  DIGITS  one-hot digit select, bit 0 = least significant digit.
- o_value  output  4*DIGITS  BCD entry, nibble 0 = LSD.
- o_count  output  $clog2(DIGITS+1)  digits currently entered.
- o_full  output  1  o_count == DIGITS.
- o_lcd_data  output  8  LCD byte.
- o_lcd_rs  output  1  1 = character data, 0 = command.
- o_lcd_valid  output  1  byte on o_lcd_data/o_lcd_rs is valid.
- i_lcd_ready  input  1  LCD writer accepts the byte this cycle when high with o_lcd_valid.

## Operation
- Debounce: a counter restarts whenever the sample differs from the previous one. After DEB_CYCLES identical samples, the value is loaded into the stable register.
- Key event: the stable register changes from all-zero to exactly one set bit. Multi-hot or non-zero-to-non-zero changes produce no event. The switches must return to all-zero before the next event.
- Digit d, not full: buffer shifts one nibble toward MSD, d enters nibble 0, and count increments. The LCD sequence is one data byte 0x30+d.
- Digit d, full: ignored. No buffer change and no LCD traffic.
- CLEAR: buffer and count are set to 0. The LCD sequence is one command byte 0x01.
- BACKSPACE, count > 0: buffer shifts toward LSD (MSD nibble ← 0) and count decrements. The LCD sequence is 3 bytes: cmd 0x10, data 0x20, cmd 0x10.
- BACKSPACE, count = 0: ignored.
- LCD FSM states:
  - IDLE
  - SEND1, SEND2, SEND3
  - Each SENDn holds o_lcd_valid high with its byte until i_lcd_ready. It then advances to the next byte, or returns to IDLE after the last byte.
- A key event arriving while the FSM is not in IDLE is dropped entirely: no buffer change and no LCD traffic. Buffer state and LCD traffic therefore never diverge.
- Display scan:
  - A divider advances o_seg_sel by one position every SCAN_DIV cycles, wrapping from bit DIGITS-1 to bit 0.
  - A position ≥ o_count shows blank (0x00).
  - When count = 0, position 0 shows "0".
- Segment codes:
  - 0 = 0xFC, 1 = 0x60, 2 = 0xDA, 3 = 0xF2, 4 = 0x66
  - 5 = 0xB6, 6 = 0xBE, 7 = 0xE0, 8 = 0xFE, 9 = 0xF6
  - blank = 0x00

## Timing
- Reset values:
  - buffer = 0, count = 0, stable and debounce state = 0
  - FSM = IDLE, o_lcd_valid = 0, o_lcd_data = 0x00, o_lcd_rs = 0
  - o_seg_sel = bit 0 set, scan divider = 0
  - o_seg = 0xFC (count 0 shows "0"), o_full = 0
- A clean press first sampled at edge k updates o_value/o_count at edge k+DEB_CYCLES+1. o_lcd_valid rises at the same edge.
- All outputs are registered.
- o_seg follows o_seg_sel and the buffer with 0 extra cycles, both registered at the same edge.
- A transfer completes on any edge with o_lcd_valid & i_lcd_ready. The next byte of a sequence is presented on the following cycle. A byte is never dropped or changed while valid is high.
- rst mid-sequence aborts the FSM to IDLE and deasserts o_lcd_valid on the next edge.
- Switch activity during reset is ignored. Debouncing restarts from zero.

## Structure
- Package keypad_pkg:
  - segment constants SEG_0..SEG_9, SEG_BLK
  - LCD constants LCD_CLEAR = 0x01, LCD_CUR_LEFT = 0x10, LCD_SPACE = 0x20, LCD_DIGIT_BASE = 0x30
  - key bit-index constants
  - LCD FSM state enum
  - function bcd_to_seg
- Sub-module sw_debounce (parameter WIDTH, DEB_CYCLES): outputs the stable vector and a one-cycle event strobe with a key index.
- Entry buffer, LCD FSM and scan logic stay in keypad_entry.

## Test plan
- Reset, then press keys 1, 2, 3 (each held > DEB_CYCLES, then released, with i_lcd_ready = 1). Required: o_value = 0x0123, o_count = 3, LCD bytes 0x31, 0x32, 0x33 with rs = 1.
- Bounce: toggle bit 9 (key 2) every 3 cycles for 40 cycles, then hold it. Required: exactly one event, and it occurs DEB_CYCLES+1 cycles after the hold starts.
- Enter 5, 6, 7, 8, 9 with DIGITS = 4. Required: o_value = 0x5678, o_full = 1, and no LCD byte for the key 9 press.
- BACKSPACE at count 2 (value 0x0056) with i_lcd_ready low for 5 cycles. Required: value = 0x0005, byte 0x10 rs = 0 held stable until ready, then 0x20 rs = 1, then 0x10 rs = 0. A digit pressed during the sequence is dropped.
- CLEAR, then press keys 0 and 1 together. Required: value = 0, count = 0, one 0x01 command, and no event for the multi-hot press.
- Scan with SCAN_DIV = 4, value 0x0042 at count 2. Required: o_seg_sel rotates every 4 cycles, showing 0x66 at position 1, 0xDA at position 0, and 0x00 at positions 2 and 3. Assert rst mid-rotation: o_seg_sel = bit 0 set on the next edge.
